// File: rtl/lsu_mem_stage.sv
//------------------------------------------------------------------------------
// lsu_mem_stage
// Memory stage for the RISC-V pipeline core. It contains the byte/half/word
// load-store unit, a data memory with configurable load latency and the
// MEM/WB pipeline register.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 256,
   parameter int LOAD_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteM,
   input  logic                  MemWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic [2:0]            funct3M,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic [31:0]           PCPlus4M,
   input  logic [4:0]            RdM,
   output logic                  StallM,
   output logic                  RegWriteW,
   output logic [1:0]            ResultSrcW,
   output logic [DATA_WIDTH-1:0] ReadDataW,
   output logic [ADDR_WIDTH-1:0] ALUResultW,
   output logic [31:0]           PCPlus4W,
   output logic [4:0]            RdW,
   output logic                  MisalignW
);

   localparam int         IDX_W    = $clog2(MEM_WORDS);
   localparam bit         MULTI    = (LOAD_LAT > 1);
   localparam logic [3:0] CNT_INIT = MULTI ? 4'(LOAD_LAT - 2) : 4'd0;

   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t state, next_state;
   logic [3:0] cnt, next_cnt;
   logic       stall, bubble;

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   logic             is_load, is_store, bad_f3, misal, fault, load_ok, store_ok;
   logic [IDX_W-1:0] idx;
   logic [1:0]       byte_off;
   logic [DATA_WIDTH-1:0] rd_word, load_data, wdata;
   logic [7:0]       rd_byte;
   logic [15:0]      rd_half;
   logic [3:0]       be;

   assign is_load  = (ResultSrcM == 2'b01) && !MemWriteM;
   assign is_store = MemWriteM;
   assign idx      = ALUResultM[IDX_W+1:2];
   assign byte_off = ALUResultM[1:0];
   assign fault    = (is_load || is_store) && (bad_f3 || misal);
   assign load_ok  = is_load && !fault;
   assign store_ok = is_store && !fault;

   // Decode access size legality and alignment for the current M instruction
   always_comb begin
      bad_f3 = 1'b0;
      misal  = 1'b0;
      case (funct3M)
         3'b000:  bad_f3 = 1'b0;
         3'b001:  misal  = byte_off[0];
         3'b010:  misal  = (byte_off != 2'b00);
         3'b100:  bad_f3 = is_store;
         3'b101:  begin
            bad_f3 = is_store;
            misal  = byte_off[0];
         end
         default: bad_f3 = 1'b1;
      endcase
   end

   // Lane selection and sign/zero extension of the addressed word
   assign rd_word = mem[idx];
   assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
   assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_data = '0;
      case (funct3M)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, rd_byte};
         3'b101:  load_data = {16'd0, rd_half};
         default: load_data = '0;
      endcase
   end

   // Store data replication and byte-enable generation
   always_comb begin
      wdata = WriteDataM;
      be    = 4'b0000;
      case (funct3M)
         3'b000:  begin
            wdata = {4{WriteDataM[7:0]}};
            be    = 4'b0001 << byte_off;
         end
         3'b001:  begin
            wdata = {2{WriteDataM[15:0]}};
            be    = byte_off[1] ? 4'b1100 : 4'b0011;
         end
         3'b010:  be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // Byte-lane memory write; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (store_ok && rst && (state == IDLE)) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Load-latency FSM state and countdown register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state logic: multi-cycle loads stall M and send bubbles to W
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      stall      = 1'b0;
      bubble     = 1'b0;
      case (state)
         IDLE: begin
            if (load_ok && MULTI) begin
               next_state = WAIT;
               next_cnt   = CNT_INIT;
               stall      = 1'b1;
               bubble     = 1'b1;
            end
         end
         WAIT: begin
            if (cnt != 4'd0) begin
               next_cnt = cnt - 4'd1;
               stall    = 1'b1;
               bubble   = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Reset gates the stall so an aborted load releases the pipeline at once
   assign StallM = stall && rst;

   // MEM/WB pipeline register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ReadDataW  <= '0;
         ALUResultW <= '0;
         PCPlus4W   <= 32'd0;
         RdW        <= 5'd0;
         MisalignW  <= 1'b0;
      end else if (bubble) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ReadDataW  <= '0;
         ALUResultW <= '0;
         PCPlus4W   <= 32'd0;
         RdW        <= 5'd0;
         MisalignW  <= 1'b0;
      end else begin
         RegWriteW  <= RegWriteM && !fault;
         ResultSrcW <= ResultSrcM;
         ReadDataW  <= load_ok ? load_data : '0;
         ALUResultW <= ALUResultM;
         PCPlus4W   <= PCPlus4M;
         RdW        <= RdM;
         MisalignW  <= fault;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
//------------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed scoreboard bench for lsu_mem_stage with LOAD_LAT=4.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_stage;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
   logic [1:0]  ResultSrcM = 2'b00;
   logic [2:0]  funct3M = 3'b000;
   logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0;
   logic [4:0]  RdM = '0;
   logic        StallM, RegWriteW, MisalignW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
   logic [4:0]  RdW;

   int checks = 0;
   int errors = 0;
   logic [31:0] pc = 32'h100;

   typedef struct packed {
      logic        rw;
      logic [1:0]  rs;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];

   lsu_mem_stage #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(256), .LOAD_LAT(LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .PCPlus4M(PCPlus4M), .RdM(RdM),
      .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ReadDataW(ReadDataW), .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W),
      .RdW(RdW), .MisalignW(MisalignW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one instruction into M, hold it while stalled, then check W
   task automatic issue(input string tag, input logic rw, input logic mw,
                        input logic [1:0] rs, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input logic [31:0] exp_data,
                        input logic exp_rw, input logic exp_mis, input int exp_stall);
      exp_t e, got;
      int n;
      @(negedge clk);
      RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
      ALUResultM = addr; WriteDataM = wd; PCPlus4M = pc; RdM = rd;
      e = '{rw: exp_rw, rs: rs, rdata: exp_data, alu: addr, pc: pc, rd: rd, mis: exp_mis};
      sb_q.push_back(e);
      pc = pc + 32'd4;
      n = 0;
      #1;
      while (StallM === 1'b1 && n < 20) begin
         n++;
         @(posedge clk); #1;
         chk({tag, "_bubble"}, {30'd0, RegWriteW, MisalignW}, 32'd0);
      end
      chk({tag, "_stall_cycles"}, n, exp_stall);
      @(posedge clk); #1;
      got = {RegWriteW, ResultSrcW, ReadDataW, ALUResultW, PCPlus4W, RdW, MisalignW};
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk({tag, "_data"}, got.rdata, e.rdata);
         chk({tag, "_regwrite"}, {31'd0, got.rw}, {31'd0, e.rw});
         chk({tag, "_misalign"}, {31'd0, got.mis}, {31'd0, e.mis});
         chk({tag, "_rd_alu_pc"}, got.alu ^ got.pc ^ {27'd0, got.rd} ^ {30'd0, got.rs},
             e.alu ^ e.pc ^ {27'd0, e.rd} ^ {30'd0, e.rs});
         chk({tag, "_rd"}, {27'd0, got.rd}, {27'd0, e.rd});
      end
   endtask

   // Global time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #12;
      chk("reset_stall", {31'd0, StallM}, 32'd0);
      chk("reset_w", {RegWriteW, ResultSrcW, RdW, MisalignW} ^ ReadDataW ^ ALUResultW ^ PCPlus4W, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Sub-word store/load
      issue("sw10",  1'b0, 1'b1, 2'b00, 3'b010, 32'h10, 32'h8899AABB, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("sb11",  1'b0, 1'b1, 2'b00, 3'b000, 32'h11, 32'h0000005A, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("lw10",  1'b1, 1'b0, 2'b01, 3'b010, 32'h10, 32'h0, 5'd5, 32'h88995ABB, 1'b1, 1'b0, LAT-1);
      issue("lb13",  1'b1, 1'b0, 2'b01, 3'b000, 32'h13, 32'h0, 5'd6, 32'hFFFFFF88, 1'b1, 1'b0, LAT-1);
      issue("lbu13", 1'b1, 1'b0, 2'b01, 3'b100, 32'h13, 32'h0, 5'd7, 32'h00000088, 1'b1, 1'b0, LAT-1);
      issue("lh12",  1'b1, 1'b0, 2'b01, 3'b001, 32'h12, 32'h0, 5'd8, 32'hFFFF8899, 1'b1, 1'b0, LAT-1);
      issue("lhu10", 1'b1, 1'b0, 2'b01, 3'b101, 32'h10, 32'h0, 5'd9, 32'h00005ABB, 1'b1, 1'b0, LAT-1);
      issue("sh12",  1'b0, 1'b1, 2'b00, 3'b001, 32'h12, 32'hFFFF1234, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("lw10b", 1'b1, 1'b0, 2'b01, 3'b010, 32'h10, 32'h0, 5'd10, 32'h12345ABB, 1'b1, 1'b0, LAT-1);

      // Misaligned and illegal accesses
      issue("sw20",  1'b0, 1'b1, 2'b00, 3'b010, 32'h20, 32'h11223344, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("lw21",  1'b1, 1'b0, 2'b01, 3'b010, 32'h21, 32'h0, 5'd11, 32'h0, 1'b0, 1'b1, 0);
      issue("sh23",  1'b0, 1'b1, 2'b00, 3'b001, 32'h23, 32'h0000FFFF, 5'd0, 32'h0, 1'b0, 1'b1, 0);
      issue("lb_f3", 1'b1, 1'b0, 2'b01, 3'b011, 32'h20, 32'h0, 5'd12, 32'h0, 1'b0, 1'b1, 0);
      issue("lw20",  1'b1, 1'b0, 2'b01, 3'b010, 32'h20, 32'h0, 5'd13, 32'h11223344, 1'b1, 1'b0, LAT-1);

      // Back-to-back store then load of the same word
      issue("sw40",  1'b0, 1'b1, 2'b00, 3'b010, 32'h40, 32'h12345678, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("lw40",  1'b1, 1'b0, 2'b01, 3'b010, 32'h40, 32'h0, 5'd14, 32'h12345678, 1'b1, 1'b0, LAT-1);

      // Address wrap
      issue("sw400", 1'b0, 1'b1, 2'b00, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0, 32'h0, 1'b0, 1'b0, 0);
      issue("lw000", 1'b1, 1'b0, 2'b01, 3'b010, 32'h000, 32'h0, 5'd15, 32'hCAFEF00D, 1'b1, 1'b0, LAT-1);

      // Non-memory instruction passes fields through
      issue("alu",   1'b1, 1'b0, 2'b00, 3'b011, 32'hDEAD, 32'hFFFF, 5'd16, 32'h0, 1'b1, 1'b0, 0);

      // Reset asserted in the middle of a multi-cycle load
      @(negedge clk);
      RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010;
      ALUResultM = 32'h40; RdM = 5'd17; PCPlus4M = pc;
      @(posedge clk); #1;
      chk("abort_stall_before", {31'd0, StallM}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_stall", {31'd0, StallM}, 32'd0);
      chk("abort_w", {RegWriteW, ResultSrcW, RdW, MisalignW} ^ ReadDataW ^ ALUResultW ^ PCPlus4W, 32'd0);
      chk("abort_rd", {27'd0, RdW}, 32'd0);
      @(negedge clk);
      RegWriteM = 1'b0; ResultSrcM = 2'b00;
      rst = 1'b1;
      issue("lw40r", 1'b1, 1'b0, 2'b01, 3'b010, 32'h40, 32'h0, 5'd18, 32'h12345678, 1'b1, 1'b0, LAT-1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
